// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven calculator sequencer. Turns key events from the
// click decoder into operands and an operator, hands one operation at a time
// to an external ALU and shows the result.
// Optional feature: define CALC_CHAIN_EN so that an operator typed after the
// second operand runs the pending operation and keeps chaining with the
// result. Without the macro that operator key is ignored.
//
// ALU handshake: alu_start is the request valid and alu_ready the ready. A
// transfer happens on a rising edge where both are high. alu_a, alu_b and
// alu_op hold steady from the first cycle alu_start is high until that
// transfer. alu_start drops in the cycle after it. The answer returns later as
// a single-cycle alu_done pulse that qualifies alu_result and alu_err.
module calc_sequencer #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  key_code,
   input  logic        alu_ready,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   input  logic        alu_err,
   output logic        alu_start,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [1:0]  alu_op,
   output logic [15:0] display_value,
   output logic        busy,
   output logic        err,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_OP_WAIT = 3'd1,
      S_ENTER_B = 3'd2,
      S_ISSUE   = 3'd3,
      S_WAIT    = 3'd4,
      S_SHOW    = 3'd5
   } state_t;

   // WAIT ends on the cycle the counter holds this value, so the state
   // lasts WAIT_LIMIT cycles when no answer arrives.
   localparam logic [7:0] LAST_CNT = 8'(WAIT_LIMIT - 1);

   state_t      state;
   state_t      state_n;

   logic [3:0]  key_s;      // key_code sampled this cycle
   logic [3:0]  key_p;      // previous sample, used for the edge check
   logic        key_ev;
   logic        is_digit;
   logic        is_oper;
   logic        is_eq;
   logic [3:0]  digit_val;
   logic [1:0]  oper_code;

   logic [15:0] acc_a;
   logic [15:0] acc_b;
   logic [15:0] result;
   logic [1:0]  op;
   logic [7:0]  wait_cnt;
   logic        err_q;
   logic [15:0] disp_hold;
   logic [15:0] disp_mux;

`ifdef CALC_CHAIN_EN
   logic        chain_q;    // the operation in flight was launched by an operator key
   logic [1:0]  next_op;    // operator to apply to the chained result
`endif

   // Append one decimal digit unless the value already has four digits.
   function automatic logic [15:0] accum(input logic [15:0] acc, input logic [3:0] d);
      logic [15:0] next_acc;
      next_acc = acc;
      if (acc < 16'd1000) begin
         next_acc = (acc * 16'd10) + {12'd0, d};
      end
      return next_acc;
   endfunction

   // Key events fire only when a code appears after an idle (zero) sample.
   assign key_ev    = (key_s != 4'd0) && (key_p == 4'd0);
   assign is_digit  = key_ev && ((key_s <= 4'd9) || (key_s == 4'd15));
   assign is_oper   = key_ev && (key_s >= 4'd10) && (key_s <= 4'd13);
   assign is_eq     = key_ev && (key_s == 4'd14);
   assign digit_val = (key_s == 4'd15) ? 4'd0 : key_s;
   // Codes 10..13 have low bits 2,3,0,1; adding 2 gives add=0, sub=1, mul=2, div=3.
   assign oper_code = key_s[1:0] + 2'd2;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_ENTER_A;
      end else begin
         state <= state_n;
      end
   end

   // Next-state selection from key events and the ALU handshake.
   always_comb begin
      state_n = state;
      case (state)
         S_ENTER_A: begin
            if (is_oper) state_n = S_OP_WAIT;
         end
         S_OP_WAIT: begin
            if (is_digit) state_n = S_ENTER_B;
         end
         S_ENTER_B: begin
            if (is_eq) begin
               state_n = S_ISSUE;
            end
`ifdef CALC_CHAIN_EN
            else if (is_oper) begin
               state_n = S_ISSUE;
            end
`endif
         end
         S_ISSUE: begin
            if (alu_ready) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (alu_done) begin
`ifdef CALC_CHAIN_EN
               state_n = (chain_q && !alu_err) ? S_OP_WAIT : S_SHOW;
`else
               state_n = S_SHOW;
`endif
            end else if (wait_cnt == LAST_CNT) begin
               state_n = S_SHOW;
            end
         end
         S_SHOW: begin
            if (is_digit) begin
               state_n = S_ENTER_A;
            end else if (is_oper) begin
               state_n = S_OP_WAIT;
            end
         end
         default: state_n = S_ENTER_A;
      endcase
   end

   // Key history, operands, operator, result, error flag and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s     <= 4'd0;
         key_p     <= 4'd0;
         acc_a     <= 16'd0;
         acc_b     <= 16'd0;
         result    <= 16'd0;
         op        <= 2'd0;
         wait_cnt  <= 8'd0;
         err_q     <= 1'b0;
         disp_hold <= 16'd0;
`ifdef CALC_CHAIN_EN
         chain_q   <= 1'b0;
         next_op   <= 2'd0;
`endif
      end else begin
         key_s <= key_code;
         key_p <= key_s;
         if ((state != S_ISSUE) && (state != S_WAIT)) begin
            disp_hold <= disp_mux;
         end
         case (state)
            S_ENTER_A: begin
               if (is_digit) begin
                  acc_a <= accum(acc_a, digit_val);
               end else if (is_oper) begin
                  op <= oper_code;
               end
            end
            S_OP_WAIT: begin
               if (is_oper) begin
                  op <= oper_code;
               end else if (is_digit) begin
                  acc_b <= {12'd0, digit_val};
               end
            end
            S_ENTER_B: begin
               if (is_digit) begin
                  acc_b <= accum(acc_b, digit_val);
               end
`ifdef CALC_CHAIN_EN
               else if (is_oper) begin
                  chain_q <= 1'b1;
                  next_op <= oper_code;
               end
`endif
            end
            S_ISSUE: begin
               if (alu_ready) wait_cnt <= 8'd0;
            end
            S_WAIT: begin
               if (alu_done) begin
                  result <= alu_result;
                  err_q  <= alu_err;
`ifdef CALC_CHAIN_EN
                  chain_q <= 1'b0;
                  if (chain_q && !alu_err) begin
                     acc_a <= alu_result;
                     acc_b <= 16'd0;
                     op    <= next_op;
                  end
`endif
               end else if (wait_cnt == LAST_CNT) begin
                  err_q  <= 1'b1;
                  result <= 16'd0;
`ifdef CALC_CHAIN_EN
                  chain_q <= 1'b0;
`endif
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_SHOW: begin
               if (is_digit) begin
                  err_q <= 1'b0;
                  acc_b <= 16'd0;
                  acc_a <= {12'd0, digit_val};
               end else if (is_oper) begin
                  err_q <= 1'b0;
                  acc_b <= 16'd0;
                  acc_a <= result;
                  op    <= oper_code;
               end
            end
            default: ;
         endcase
      end
   end

   // Display source per state; the last shown value is frozen while busy.
   always_comb begin
      disp_mux = disp_hold;
      case (state)
         S_ENTER_A, S_OP_WAIT: disp_mux = acc_a;
         S_ENTER_B:            disp_mux = acc_b;
         S_SHOW:               disp_mux = result;
         default:              disp_mux = disp_hold;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      alu_start     = (state == S_ISSUE);
      busy          = (state == S_ISSUE) || (state == S_WAIT);
      alu_a         = acc_a;
      alu_b         = acc_b;
      alu_op        = op;
      err           = err_q;
      display_value = disp_mux;
      fsm_state     = state;
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus randomized calculations,
// with the ALU played by the bench and requests checked against a queue.
`timescale 1ns/1ps
module tb_calc_sequencer;

   localparam int WAIT_LIMIT = 255;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        alu_ready = 1'b1;
   logic        alu_done = 1'b0;
   logic [15:0] alu_result = 16'd0;
   logic        alu_err = 1'b0;
   logic        alu_start;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [1:0]  alu_op;
   logic [15:0] display_value;
   logic        busy;
   logic        err;
   logic [2:0]  fsm_state;

   calc_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_code      (key_code),
      .alu_ready     (alu_ready),
      .alu_done      (alu_done),
      .alu_result    (alu_result),
      .alu_err       (alu_err),
      .alu_start     (alu_start),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_op        (alu_op),
      .display_value (display_value),
      .busy          (busy),
      .err           (err),
      .fsm_state     (fsm_state)
   );

   // Clock.
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Scoreboard: expected ALU requests as {op, a, b}.
   logic [33:0] exp_q[$];
   // Answers the bench ALU returns, in order.
   logic [15:0] resp_res_q[$];
   logic        resp_err_q[$];
   int          resp_delay = 3;
   bit          resp_en = 1'b1;
   int          cnt_down = 0;

   int n_xfer  = 0;
   int n_start = 0;
   int n_busy  = 0;

   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic fire_done();
      alu_done = 1'b1;
      if (resp_res_q.size() > 0) begin
         alu_result = resp_res_q.pop_front();
         alu_err    = resp_err_q.pop_front();
      end
   endtask

   // One clock: observe pre-edge handshake, advance, then play the ALU.
   task automatic cycle();
      logic hs;
      hs = alu_start && alu_ready;
      if (alu_start) n_start++;
      if (busy) n_busy++;
      if (hs) begin
         n_xfer++;
         if (exp_q.size() == 0) check("unexpected_req", 34'(exp_q.size()), 34'd1);
         else check("alu_request", {alu_op, alu_a, alu_b}, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      if (hs && resp_en) begin
         if (resp_delay == 0) fire_done();
         else cnt_down = resp_delay;
      end else if (cnt_down > 0) begin
         cnt_down--;
         if (cnt_down == 0) fire_done();
      end
   endtask

   task automatic press(input logic [3:0] code);
      key_code = code;
      cycle();
      key_code = 4'd0;
      cycle();
      cycle();
   endtask

   task automatic do_reset();
      key_code = 4'd0;
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy && (k < budget)) begin
         cycle();
         k++;
      end
      check("idle_timeout", 34'(busy), 34'd0);
   endtask

   function automatic logic [3:0] dkey(input int d);
      return (d == 0) ? 4'd15 : 4'(d);
   endfunction

   // Decimal entry rule: a digit is appended only while the value is below 1000.
   function automatic logic [15:0] accum(input logic [15:0] acc, input int d);
      if (acc < 16'd1000) return 16'(int'(acc) * 10 + d);
      return acc;
   endfunction

   initial begin
      logic [15:0] prev_res;
      int k;
      prev_res = 16'd0;

      // Reset state.
      #12;
      check("rst_display", 34'(display_value), 34'd0);
      check("rst_busy", 34'(busy), 34'd0);
      check("rst_err", 34'(err), 34'd0);
      check("rst_start", 34'(alu_start), 34'd0);
      check("rst_state", 34'(fsm_state), 34'd0);
      cycle();
      rst_n = 1'b1;
      cycle();

      // 12 + 3 with a three-cycle ALU.
      exp_q.push_back({2'd0, 16'd12, 16'd3});
      resp_res_q.push_back(16'd15);
      resp_err_q.push_back(1'b0);
      resp_delay = 3;
      press(4'd1);
      press(4'd2);
      check("basic_acc_a", 34'(display_value), 34'd12);
      press(4'd10);
      check("basic_opwait", 34'(display_value), 34'd12);
      press(4'd3);
      check("basic_acc_b", 34'(display_value), 34'd3);
      n_start = 0; n_busy = 0; n_xfer = 0;
      press(4'd14);
      wait_idle(50);
      check("basic_start_cycles", 34'(n_start), 34'd1);
      check("basic_xfer", 34'(n_xfer), 34'd1);
      check("basic_busy_cycles", 34'(n_busy), 34'(resp_delay + 2));
      check("basic_display", 34'(display_value), 34'd15);
      check("basic_err", 34'(err), 34'd0);

      // Held and directly changed keys give a single event.
      do_reset();
      key_code = 4'd7;
      repeat (10) cycle();
      key_code = 4'd0;
      cycle(); cycle();
      check("held_key", 34'(display_value), 34'd7);
      key_code = 4'd1;
      cycle(); cycle();
      key_code = 4'd2;
      cycle(); cycle();
      key_code = 4'd0;
      cycle(); cycle();
      check("changed_key", 34'(display_value), 34'd71);
      do_reset();
      for (int i = 1; i <= 5; i++) press(4'(i));
      check("four_digit_cap", 34'(display_value), 34'd1234);

      // ALU not ready for five cycles of ISSUE.
      do_reset();
      press(4'd4); press(4'd13); press(4'd8);
      exp_q.push_back({2'd3, 16'd4, 16'd8});
      resp_res_q.push_back(16'd2);
      resp_err_q.push_back(1'b0);
      resp_delay = 2;
      alu_ready = 1'b0;
      press(4'd14);
      k = 0;
      while (!alu_start && (k < 10)) begin cycle(); k++; end
      n_start = 0; n_xfer = 0;
      repeat (5) begin
         check("stall_stable", {alu_start, alu_op, alu_a, alu_b}, {1'b1, 2'd3, 16'd4, 16'd8});
         cycle();
      end
      alu_ready = 1'b1;
      check("stall_stable", {alu_start, alu_op, alu_a, alu_b}, {1'b1, 2'd3, 16'd4, 16'd8});
      cycle();
      wait_idle(50);
      check("stall_start_cycles", 34'(n_start), 34'd6);
      check("stall_xfer", 34'(n_xfer), 34'd1);
      check("stall_display", 34'(display_value), 34'd2);

      // A done pulse outside WAIT changes nothing.
      press(4'd5);
      alu_done = 1'b1;
      alu_result = 16'h1234;
      alu_err = 1'b1;
      cycle();
      alu_err = 1'b0;
      check("stray_done_display", 34'(display_value), 34'd5);
      check("stray_done_err", 34'(err), 34'd0);

      // Timeout with no answer.
      do_reset();
      press(4'd6); press(4'd12); press(4'd7);
      exp_q.push_back({2'd2, 16'd6, 16'd7});
      resp_en = 1'b0;
      n_busy = 0;
      press(4'd14);
      wait_idle(400);
      check("timeout_busy_cycles", 34'(n_busy), 34'(1 + WAIT_LIMIT));
      check("timeout_err", 34'(err), 34'd1);
      check("timeout_display", 34'(display_value), 34'd0);
      press(4'd4);
      check("timeout_clear_err", 34'(err), 34'd0);
      check("timeout_clear_display", 34'(display_value), 34'd4);
      resp_en = 1'b1;

      // Reset during WAIT abandons the operation; the late answer is ignored.
      do_reset();
      press(4'd9); press(4'd11); press(4'd2);
      exp_q.push_back({2'd1, 16'd9, 16'd2});
      resp_res_q.push_back(16'd99);
      resp_err_q.push_back(1'b1);
      resp_delay = 6;
      press(4'd14);
      cycle(); cycle();
      check("abort_in_wait", 34'(busy), 34'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_outputs", {alu_start, busy, err, alu_op, display_value, 3'(fsm_state)}, 34'd0);
      check("abort_operands", {2'd0, alu_a, alu_b}, 34'd0);
      cycle();
      rst_n = 1'b1;
      repeat (8) cycle();
      check("abort_done_fired", 34'(resp_res_q.size()), 34'd0);
      check("abort_display", 34'(display_value), 34'd0);
      check("abort_state", 34'(fsm_state), 34'd0);
      check("abort_err", 34'(err), 34'd0);

      // Randomized calculations.
      do_reset();
      for (int it = 0; it < 10; it++) begin
         logic [15:0] ea;
         logic [15:0] eb;
         logic [15:0] res;
         int op;
         int nd;
         int d;
         int stall;
         bit er;
         bit cont;
         cont = (it > 0) && ($urandom_range(0, 1) == 1);
         if (cont) begin
            op = $urandom_range(0, 3);
            press(4'(10 + op));
            ea = prev_res;
         end else begin
            nd = $urandom_range(1, 6);
            ea = 16'd0;
            for (int j = 0; j < nd; j++) begin
               d = $urandom_range(0, 9);
               press(dkey(d));
               ea = accum(ea, d);
            end
            check("rnd_acc_a", 34'(display_value), 34'(ea));
            press(4'd14);
            check("rnd_eq_in_a", 34'(display_value), 34'(ea));
            op = $urandom_range(0, 3);
            press(4'(10 + op));
         end
         check("rnd_opwait", 34'(display_value), 34'(ea));
         if ($urandom_range(0, 1) == 1) begin
            op = $urandom_range(0, 3);
            press(4'(10 + op));
         end
         nd = $urandom_range(1, 6);
         eb = 16'd0;
         for (int j = 0; j < nd; j++) begin
            d = $urandom_range(0, 9);
            press(dkey(d));
            eb = accum(eb, d);
         end
         check("rnd_acc_b", 34'(display_value), 34'(eb));
`ifndef CALC_CHAIN_EN
         press(4'(10 + $urandom_range(0, 3)));
         check("rnd_op_in_b", 34'(display_value), 34'(eb));
`endif
         res = 16'($urandom);
         er = ($urandom_range(0, 3) == 0);
         resp_delay = $urandom_range(0, 6);
         stall = $urandom_range(0, 4);
         exp_q.push_back({2'(op), ea, eb});
         resp_res_q.push_back(res);
         resp_err_q.push_back(er);
         n_xfer = 0;
         alu_ready = (stall == 0);
         press(4'd14);
         repeat (stall) cycle();
         alu_ready = 1'b1;
         wait_idle(60);
         check("rnd_xfer", 34'(n_xfer), 34'd1);
         check("rnd_display", 34'(display_value), 34'(res));
         check("rnd_err", 34'(err), 34'(er));
         prev_res = res;
      end

`ifdef CALC_CHAIN_EN
      // Chained operator: 2+3 then *4.
      do_reset();
      exp_q.push_back({2'd0, 16'd2, 16'd3});
      exp_q.push_back({2'd2, 16'd5, 16'd4});
      resp_res_q.push_back(16'd5);
      resp_err_q.push_back(1'b0);
      resp_res_q.push_back(16'd20);
      resp_err_q.push_back(1'b0);
      resp_delay = 2;
      n_xfer = 0;
      press(4'd2); press(4'd10); press(4'd3); press(4'd12);
      wait_idle(60);
      check("chain_mid_display", 34'(display_value), 34'd5);
      check("chain_mid_state", 34'(fsm_state), 34'd1);
      press(4'd4); press(4'd14);
      wait_idle(60);
      check("chain_display", 34'(display_value), 34'd20);
      check("chain_xfer", 34'(n_xfer), 34'd2);
`endif

      check("scoreboard_empty", 34'(exp_q.size()), 34'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
